ldst_control_sequencer: RTL and testbench

- Hardwired control sequencer for the memory-class instructions ld, ldi and st.
- Replaces hand-driven control pulses with an FSM that emits the datapath control strobes for T0..T7 and handles variable-latency memory through a ready handshake.
- Sits between the CPU datapath control inputs and the IR/memory interface.
- Flags illegal opcodes and memory timeouts with a sticky fault.

---
 rtl/ldst_control_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_ldst_control_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldst_control_sequencer.sv
// rtl/ldst_control_sequencer.sv - ld/ldi/st control sequencer with memory-ready handshake
module ldst_control_sequencer #(
    parameter int                  IR_W     = 32,
    parameter int                  OPCODE_W = 5,
    parameter logic [OPCODE_W-1:0] OP_LD    = 5'd0,
    parameter logic [OPCODE_W-1:0] OP_LDI   = 5'd1,
    parameter logic [OPCODE_W-1:0] OP_ST    = 5'd2,
    parameter int                  WAIT_MAX = 15,
    parameter int                  CNT_W    = 4
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            run,
    input  logic [IR_W-1:0] ir,
    input  logic            mem_ready,
    output logic            PCout,
    output logic            IncPC,
    output logic            Zin,
    output logic            MARin,
    output logic            Zlowout,
    output logic            PCin,
    output logic            memRead,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Grb,
    output logic            BAout,
    output logic            Yin,
    output logic            Cout,
    output logic            ADD,
    output logic            Gra,
    output logic            Rin,
    output logic            Rout,
    output logic            ramEnable,
    output logic [3:0]      step,
    output logic            instr_done,
    output logic            fault,
    output logic [1:0]      fault_code
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_DEC   = 4'd4;
    localparam logic [3:0] S_T3    = 4'd5;
    localparam logic [3:0] S_T4    = 4'd6;
    localparam logic [3:0] S_T5    = 4'd7;
    localparam logic [3:0] S_T6    = 4'd8;
    localparam logic [3:0] S_T7    = 4'd9;
    localparam logic [3:0] S_FAULT = 4'd10;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ILLEGAL = 2'd1;
    localparam logic [1:0] FC_RD_TO   = 2'd2;
    localparam logic [1:0] FC_WR_TO   = 2'd3;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);

    logic [3:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic                fault_q, fault_d;
    logic [1:0]          code_q, code_d;

    logic [OPCODE_W-1:0] op_in;
    logic                op_legal;
    logic                timed_out;
    logic [3:0]          end_state;
    logic                unused_ir_bits;

    assign op_in          = ir[IR_W-1 -: OPCODE_W];
    assign op_legal       = (op_in == OP_LD) || (op_in == OP_LDI) || (op_in == OP_ST);
    assign timed_out      = (cnt_q == WAIT_LIMIT);
    assign end_state      = run ? S_T0 : S_IDLE;
    assign unused_ir_bits = ^ir[IR_W-OPCODE_W-1:0];

    // State, wait counter, latched opcode and sticky fault registers
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    // Next-state logic; the counter defaults to zero so every state entry clears it
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        op_d    = op_q;
        fault_d = fault_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1: begin
                if (mem_ready) begin
                    state_d = S_T2;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    code_d  = FC_RD_TO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_T2:   state_d = S_DEC;
            S_DEC: begin
                op_d = op_in;
                if (op_legal) begin
                    state_d = S_T3;
                end else begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    code_d  = FC_ILLEGAL;
                end
            end
            S_T3:   state_d = S_T4;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (op_q == OP_LDI) ? end_state : S_T6;
            S_T6: begin
                if (op_q != OP_LD) begin
                    state_d = S_T7;
                end else if (mem_ready) begin
                    state_d = S_T7;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    code_d  = FC_RD_TO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_T7: begin
                if (op_q == OP_LD) begin
                    state_d = end_state;
                end else if (mem_ready) begin
                    state_d = end_state;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    code_d  = FC_WR_TO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobe decode from the state register; st completion also needs mem_ready
    always_comb begin
        PCout      = 1'b0;
        IncPC      = 1'b0;
        Zin        = 1'b0;
        MARin      = 1'b0;
        Zlowout    = 1'b0;
        PCin       = 1'b0;
        memRead    = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Grb        = 1'b0;
        BAout      = 1'b0;
        Yin        = 1'b0;
        Cout       = 1'b0;
        ADD        = 1'b0;
        Gra        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        ramEnable  = 1'b0;
        instr_done = 1'b0;
        step       = 4'd15;
        case (state_q)
            S_T0: begin
                step  = 4'd0;
                PCout = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
                MARin = 1'b1;
            end
            S_T1: begin
                step    = 4'd1;
                Zlowout = 1'b1;
                PCin    = (cnt_q == '0);  // only the first fetch cycle loads PC
                memRead = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                step   = 4'd2;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_DEC: step = 4'd2;
            S_T3: begin
                step  = 4'd3;
                Grb   = 1'b1;
                BAout = 1'b1;
                Yin   = 1'b1;
            end
            S_T4: begin
                step = 4'd4;
                Cout = 1'b1;
                ADD  = 1'b1;
                Zin  = 1'b1;
            end
            S_T5: begin
                step    = 4'd5;
                Zlowout = 1'b1;
                if (op_q == OP_LDI) begin
                    Gra        = 1'b1;
                    Rin        = 1'b1;
                    instr_done = 1'b1;
                end else begin
                    MARin = 1'b1;
                end
            end
            S_T6: begin
                step  = 4'd6;
                MDRin = 1'b1;
                if (op_q == OP_LD) begin
                    memRead = 1'b1;
                end else begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                end
            end
            S_T7: begin
                step   = 4'd7;
                MDRout = 1'b1;
                if (op_q == OP_LD) begin
                    Gra        = 1'b1;
                    Rin        = 1'b1;
                    instr_done = 1'b1;
                end else begin
                    ramEnable  = 1'b1;
                    instr_done = mem_ready;
                end
            end
            default: step = 4'd15;
        endcase
    end

    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_ldst_control_sequencer.sv
// tb/tb_ldst_control_sequencer.sv - randomized self-checking bench for ldst_control_sequencer
module tb_ldst_control_sequencer;

    logic        clock = 1'b0;
    logic        clear, run, mem_ready;
    logic [31:0] ir;
    logic PCout, IncPC, Zin, MARin, Zlowout, PCin, memRead, MDRin, MDRout, IRin;
    logic Grb, BAout, Yin, Cout, ADD, Gra, Rin, Rout, ramEnable;
    logic [3:0] step;
    logic       instr_done, fault;
    logic [1:0] fault_code;

    int errors = 0;
    int checks = 0;

    localparam logic [18:0] M_PCOUT = 19'b1 << 18;
    localparam logic [18:0] M_INCPC = 19'b1 << 17;
    localparam logic [18:0] M_ZIN   = 19'b1 << 16;
    localparam logic [18:0] M_MARIN = 19'b1 << 15;
    localparam logic [18:0] M_ZLOW  = 19'b1 << 14;
    localparam logic [18:0] M_PCIN  = 19'b1 << 13;
    localparam logic [18:0] M_MEMRD = 19'b1 << 12;
    localparam logic [18:0] M_MDRIN = 19'b1 << 11;
    localparam logic [18:0] M_MDROU = 19'b1 << 10;
    localparam logic [18:0] M_IRIN  = 19'b1 << 9;
    localparam logic [18:0] M_GRB   = 19'b1 << 8;
    localparam logic [18:0] M_BAOUT = 19'b1 << 7;
    localparam logic [18:0] M_YIN   = 19'b1 << 6;
    localparam logic [18:0] M_COUT  = 19'b1 << 5;
    localparam logic [18:0] M_ADD   = 19'b1 << 4;
    localparam logic [18:0] M_GRA   = 19'b1 << 3;
    localparam logic [18:0] M_RIN   = 19'b1 << 2;
    localparam logic [18:0] M_ROUT  = 19'b1 << 1;
    localparam logic [18:0] M_RAMEN = 19'b1;

    typedef struct {
        logic [18:0] strb;
        logic [3:0]  step;
        logic        done;
        logic        flt;
        logic [1:0]  code;
        logic        mr;
        logic        runv;
        logic        clr;
        logic [31:0] irv;
    } cyc_t;

    cyc_t eq[$];
    cyc_t oq[$];

    ldst_control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .IncPC(IncPC), .Zin(Zin), .MARin(MARin),
        .Zlowout(Zlowout), .PCin(PCin), .memRead(memRead), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin),
        .Grb(Grb), .BAout(BAout), .Yin(Yin), .Cout(Cout), .ADD(ADD),
        .Gra(Gra), .Rin(Rin), .Rout(Rout), .ramEnable(ramEnable),
        .step(step), .instr_done(instr_done), .fault(fault), .fault_code(fault_code)
    );

    always #5 clock = ~clock;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [27:0] pack(input cyc_t r);
        return {r.strb, r.step, r.done, r.flt, r.code};
    endfunction

    task automatic push(input logic [18:0] s, input logic [3:0] st, input logic d,
                        input logic f, input logic [1:0] c, input logic mr,
                        input logic rv, input logic [31:0] iv);
        cyc_t r;
        r.strb = s; r.step = st; r.done = d; r.flt = f; r.code = c;
        r.mr = mr; r.runv = rv; r.clr = 1'b0; r.irv = iv;
        eq.push_back(r);
    endtask

    task automatic fault_tail(input logic [1:0] c);
        for (int k = 0; k < 3; k++) push('0, 4'd15, 1'b0, 1'b1, c, rb(), 1'b1, $urandom);
    endtask

    // Instruction-level model: a wait of w>15 cycles means the memory never answers
    task automatic gen_instr(input logic [31:0] iv, input int w1, input int w2,
                             input logic from_idle, input logic cont);
        logic [4:0] op;
        op = iv[31:27];
        if (from_idle) push('0, 4'd15, 1'b0, 1'b0, 2'd0, rb(), 1'b1, iv);
        push(M_PCOUT | M_INCPC | M_ZIN | M_MARIN, 4'd0, 1'b0, 1'b0, 2'd0, rb(), rb(), iv);
        for (int k = 0; k <= w1 && k < 16; k++)
            push(M_ZLOW | M_MEMRD | M_MDRIN | ((k == 0) ? M_PCIN : 19'd0), 4'd1,
                 1'b0, 1'b0, 2'd0, (k == w1), rb(), iv);
        if (w1 > 15) begin fault_tail(2'd2); return; end
        push(M_MDROU | M_IRIN, 4'd2, 1'b0, 1'b0, 2'd0, rb(), rb(), iv);
        push('0, 4'd2, 1'b0, 1'b0, 2'd0, rb(), rb(), iv);
        if (op > 5'd2) begin fault_tail(2'd1); return; end
        push(M_GRB | M_BAOUT | M_YIN, 4'd3, 1'b0, 1'b0, 2'd0, rb(), rb(), $urandom);
        push(M_COUT | M_ADD | M_ZIN, 4'd4, 1'b0, 1'b0, 2'd0, rb(), rb(), $urandom);
        if (op == 5'd1) begin
            push(M_ZLOW | M_GRA | M_RIN, 4'd5, 1'b1, 1'b0, 2'd0, rb(), cont, $urandom);
        end else begin
            push(M_ZLOW | M_MARIN, 4'd5, 1'b0, 1'b0, 2'd0, rb(), rb(), $urandom);
            if (op == 5'd0) begin
                for (int k = 0; k <= w2 && k < 16; k++)
                    push(M_MEMRD | M_MDRIN, 4'd6, 1'b0, 1'b0, 2'd0, (k == w2), rb(), $urandom);
                if (w2 > 15) begin fault_tail(2'd2); return; end
                push(M_MDROU | M_GRA | M_RIN, 4'd7, 1'b1, 1'b0, 2'd0, rb(), cont, $urandom);
            end else begin
                push(M_GRA | M_ROUT | M_MDRIN, 4'd6, 1'b0, 1'b0, 2'd0, rb(), rb(), $urandom);
                for (int k = 0; k <= w2 && k < 16; k++)
                    push(M_MDROU | M_RAMEN, 4'd7, (k == w2), 1'b0, 2'd0, (k == w2),
                         (k == w2) ? cont : rb(), $urandom);
                if (w2 > 15) begin fault_tail(2'd3); return; end
            end
        end
        if (!cont) push('0, 4'd15, 1'b0, 1'b0, 2'd0, rb(), 1'b0, $urandom);
    endtask

    // Drive the queued stimulus, one record per clock, and capture what the DUT shows
    task automatic play();
        cyc_t r;
        oq.delete();
        for (int i = 0; i < eq.size(); i++) begin
            @(negedge clock);
            mem_ready = eq[i].mr;
            run       = eq[i].runv;
            ir        = eq[i].irv;
            clear     = eq[i].clr;
            #1;
            r = eq[i];
            r.strb = {PCout, IncPC, Zin, MARin, Zlowout, PCin, memRead, MDRin, MDRout, IRin,
                      Grb, BAout, Yin, Cout, ADD, Gra, Rin, Rout, ramEnable};
            r.step = step; r.done = instr_done; r.flt = fault; r.code = fault_code;
            oq.push_back(r);
        end
        clear = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear = 1'b1; run = 1'b0; mem_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        clear = 1'b1; run = 1'b1; mem_ready = 1'b1; ir = 32'h10800087;
        @(negedge clock);
        @(negedge clock);
        #1;
        checks++;
        if ({PCout, IncPC, Zin, MARin, Zlowout, PCin, memRead, MDRin, MDRout, IRin, Grb,
             BAout, Yin, Cout, ADD, Gra, Rin, Rout, ramEnable} !== 19'd0) begin
            errors++; $display("FAIL reset_strobes got=%b want=0", {PCout, MARin, memRead, ramEnable});
        end
        checks++;
        if (step !== 4'd15) begin errors++; $display("FAIL reset_step got=%0d want=15", step); end
        checks++;
        if (instr_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", instr_done); end
        checks++;
        if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b want=0", fault); end
        checks++;
        if (fault_code !== 2'd0) begin errors++; $display("FAIL reset_code got=%0d want=0", fault_code); end
        clear = 1'b0; run = 1'b0;
    endtask

    task automatic test_st();
        int t0, td, rams;
        do_reset();
        eq.delete();
        gen_instr(32'h10800087, 0, 0, 1'b1, 1'b0);
        play();
        t0 = -1; td = -1; rams = 0;
        for (int i = 0; i < eq.size(); i++) begin
            checks++;
            if (pack(oq[i]) !== pack(eq[i])) begin
                errors++; $display("FAIL st cyc=%0d got=%07h want=%07h", i, pack(oq[i]), pack(eq[i]));
            end
            if (oq[i].strb[0]) rams++;
            if (oq[i].step == 4'd0 && t0 < 0) t0 = i;
            if (oq[i].done && td < 0) td = i;
        end
        checks++;
        if (rams != 1) begin errors++; $display("FAIL st_ramen_cycles got=%0d want=1", rams); end
        checks++;
        if (td - t0 + 1 != 9) begin errors++; $display("FAIL st_latency got=%0d want=9", td - t0 + 1); end
    endtask

    task automatic test_ld();
        int rd;
        do_reset();
        eq.delete();
        gen_instr(32'h00880087, 0, 3, 1'b1, 1'b0);
        play();
        rd = 0;
        for (int i = 0; i < eq.size(); i++) begin
            checks++;
            if (pack(oq[i]) !== pack(eq[i])) begin
                errors++; $display("FAIL ld cyc=%0d got=%07h want=%07h", i, pack(oq[i]), pack(eq[i]));
            end
            if (oq[i].step == 4'd6 && oq[i].strb[12] && oq[i].strb[11]) rd++;
        end
        checks++;
        if (rd != 4) begin errors++; $display("FAIL ld_t6_read_cycles got=%0d want=4", rd); end
    endtask

    task automatic test_ldi_and_boundary();
        do_reset();
        eq.delete();
        gen_instr(32'h08100005, 2, 0, 1'b1, 1'b0);
        gen_instr({5'd0, 27'h0123456}, 15, 15, 1'b1, 1'b0);
        gen_instr({5'd2, 27'h7654321}, 15, 15, 1'b1, 1'b0);
        play();
        for (int i = 0; i < eq.size(); i++) begin
            checks++;
            if (pack(oq[i]) !== pack(eq[i])) begin
                errors++; $display("FAIL ldi_boundary cyc=%0d got=%07h want=%07h", i, pack(oq[i]), pack(eq[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        eq.delete();
        gen_instr(32'h10800087, 0, 0, 1'b1, 1'b1);
        gen_instr(32'h10800087, 1, 2, 1'b0, 1'b0);
        play();
        for (int i = 0; i < eq.size(); i++) begin
            checks++;
            if (pack(oq[i]) !== pack(eq[i])) begin
                errors++; $display("FAIL back_to_back cyc=%0d got=%07h want=%07h", i, pack(oq[i]), pack(eq[i]));
            end
        end
    endtask

    task automatic test_faults();
        logic [31:0] bad [4];
        int          w1s [4];
        int          w2s [4];
        bad[0] = {5'd9, 27'h0}; w1s[0] = 0;  w2s[0] = 0;
        bad[1] = 32'h10800087;  w1s[1] = 16; w2s[1] = 0;
        bad[2] = 32'h00880087;  w1s[2] = 1;  w2s[2] = 16;
        bad[3] = 32'h10800087;  w1s[3] = 0;  w2s[3] = 16;
        for (int t = 0; t < 5; t++) begin
            do_reset();
            eq.delete();
            if (t < 4) gen_instr(bad[t], w1s[t], w2s[t], 1'b1, 1'b1);
            else gen_instr({5'(3 + $urandom_range(0, 28)), 27'($urandom)}, 0, 0, 1'b1, 1'b1);
            play();
            for (int i = 0; i < eq.size(); i++) begin
                checks++;
                if (pack(oq[i]) !== pack(eq[i])) begin
                    errors++; $display("FAIL fault%0d cyc=%0d got=%07h want=%07h", t, i, pack(oq[i]), pack(eq[i]));
                end
            end
        end
    endtask

    task automatic test_clear_mid();
        do_reset();
        eq.delete();
        gen_instr(32'h10800087, 0, 0, 1'b1, 1'b0);
        while (eq[eq.size()-1].step != 4'd6) void'(eq.pop_back());
        eq[eq.size()-1].clr = 1'b1;
        push('0, 4'd15, 1'b0, 1'b0, 2'd0, rb(), 1'b1, 32'h10800087);
        push(M_PCOUT | M_INCPC | M_ZIN | M_MARIN, 4'd0, 1'b0, 1'b0, 2'd0, rb(), rb(), 32'h10800087);
        play();
        for (int i = 0; i < eq.size(); i++) begin
            checks++;
            if (pack(oq[i]) !== pack(eq[i])) begin
                errors++; $display("FAIL clear_mid cyc=%0d got=%07h want=%07h", i, pack(oq[i]), pack(eq[i]));
            end
        end
    endtask

    task automatic test_random();
        logic prev_cont, cont;
        logic [4:0] op;
        do_reset();
        eq.delete();
        prev_cont = 1'b0;
        for (int n = 0; n < 25; n++) begin
            op   = 5'($urandom_range(0, 2));
            cont = (n == 24) ? 1'b0 : rb();
            gen_instr({op, 27'($urandom)}, $urandom_range(0, 15), $urandom_range(0, 15),
                      !prev_cont, cont);
            prev_cont = cont;
        end
        play();
        for (int i = 0; i < eq.size(); i++) begin
            checks++;
            if (pack(oq[i]) !== pack(eq[i])) begin
                errors++; $display("FAIL random cyc=%0d got=%07h want=%07h", i, pack(oq[i]), pack(eq[i]));
            end
        end
    endtask

    initial begin
        clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;
        test_reset();
        test_st();
        test_ld();
        test_ldi_and_boundary();
        test_back_to_back();
        test_faults();
        test_clear_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
